palindrome_search_ctrl: RTL and testbench

Sequencing controller for the palindrome-product search. It walks factor pairs (a, b) over a programmable range, owns the product multiplier, and farms each candidate product out to a shared, multi-cycle palindrome checker through a valid/ready request and response handshake. It prunes rows and terminates early, tracks the largest palindrome found, and reports it together with its factors under a start/busy/done handshake to the top-level Euler harness.

---
 rtl/palindrome_search_ctrl_if.sv | 32 +++
 rtl/palindrome_search_ctrl.sv | 159 +++++++++++++++
 tb/tb_palindrome_search_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/palindrome_search_ctrl_if.sv
// Check-request / response channel between the palindrome search controller
// and the shared, multi-cycle palindrome checker.
//   chk_valid  controller -> checker : request valid, held until chk_ready
//   chk_ready  checker -> controller : request accepted this cycle
//   chk_value  controller -> checker : product to test
//   rsp_valid  checker -> controller : one-cycle response pulse
//   rsp_pal    checker -> controller : chk_value is a palindrome
interface palindrome_search_ctrl_if #(
  parameter int PW = 20
);
  logic          chk_valid;
  logic          chk_ready;
  logic [PW-1:0] chk_value;
  logic          rsp_valid;
  logic          rsp_pal;

  modport master (
    output chk_valid,
    output chk_value,
    input  chk_ready,
    input  rsp_valid,
    input  rsp_pal
  );

  modport slave (
    input  chk_valid,
    input  chk_value,
    output chk_ready,
    output rsp_valid,
    output rsp_pal
  );
endinterface

// File: rtl/palindrome_search_ctrl.sv
// Palindrome-product search sequencer. Walks factor pairs (a, b) from hi
// downwards with a >= b, prunes rows that cannot beat the best palindrome
// found, sends each surviving product to the external checker over the chk
// interface and keeps the largest palindrome with its factors.
//   clk, rst_n          clock, asynchronous active-low reset
//   start, lo, hi       search request and inclusive factor range
//   busy, done          search in progress / complete (done held)
//   result              largest palindrome found
//   factor_a, factor_b  its factors, factor_a >= factor_b
//   checks              number of requests accepted by the checker
//   chk                 request/response channel to the checker
//
// state | meaning
// IDLE  | waiting for start, nothing searched since reset
// EVAL  | decide: finish, prune row, or issue product a*b
// ISSUE | chk_valid held with chk_value until chk_ready
// WAIT  | request accepted, waiting for rsp_valid
// DONE  | search finished, outputs frozen until next start
module palindrome_search_ctrl #(
  parameter int W  = 10,
  parameter int PW = 2 * W,
  parameter int CW = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [W-1:0]            lo,
  input  logic [W-1:0]            hi,
  output logic                    busy,
  output logic                    done,
  output logic [PW-1:0]           result,
  output logic [W-1:0]            factor_a,
  output logic [W-1:0]            factor_b,
  output logic [CW-1:0]           checks,
  palindrome_search_ctrl_if.master chk
);

  typedef enum logic [2:0] {IDLE, EVAL, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_n;
  logic [W-1:0]  a, a_n, b, b_n;
  logic [W-1:0]  lo_r, lo_r_n;
  logic [PW-1:0] best, best_n;
  logic [W-1:0]  fa, fa_n, fb, fb_n;
  logic [CW-1:0] checks_r, checks_n;
  logic [PW-1:0] val_r, val_n;

  logic [W-1:0]  lo_e;
  logic [PW-1:0] prod;
  logic [PW-1:0] sq;

  // lo is clamped to 1 so the a-1 / b-1 steps can never wrap below zero.
  assign lo_e = (lo == '0) ? W'(1) : lo;
  assign prod = PW'(a) * PW'(b);
  assign sq   = PW'(a) * PW'(a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      lo_r     <= '0;
      best     <= '0;
      fa       <= '0;
      fb       <= '0;
      checks_r <= '0;
      val_r    <= '0;
    end else begin
      state    <= state_n;
      a        <= a_n;
      b        <= b_n;
      lo_r     <= lo_r_n;
      best     <= best_n;
      fa       <= fa_n;
      fb       <= fb_n;
      checks_r <= checks_n;
      val_r    <= val_n;
    end
  end

  always_comb begin
    state_n  = state;
    a_n      = a;
    b_n      = b;
    lo_r_n   = lo_r;
    best_n   = best;
    fa_n     = fa;
    fb_n     = fb;
    checks_n = checks_r;
    val_n    = val_r;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          lo_r_n   = lo_e;
          best_n   = '0;
          fa_n     = '0;
          fb_n     = '0;
          checks_n = '0;
          if (lo_e > hi) begin
            state_n = DONE;
          end else begin
            a_n     = hi;
            b_n     = hi;
            state_n = EVAL;
          end
        end
      end
      EVAL: begin
        // a*a is the largest product left in any remaining row, so once it
        // cannot beat best the whole search is over.
        if ((a < lo_r) || (sq <= best)) begin
          state_n = DONE;
        end else if ((b < lo_r) || (prod <= best)) begin
          a_n = a - W'(1);
          b_n = a - W'(1);
        end else begin
          val_n   = prod;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (chk.chk_ready) begin
          checks_n = checks_r + CW'(1);
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (chk.rsp_valid) begin
          if (chk.rsp_pal) begin
            // Any later hit in this row has a smaller b, hence a smaller
            // product, so the row is finished.
            best_n = val_r;
            fa_n   = a;
            fb_n   = b;
            a_n    = a - W'(1);
            b_n    = a - W'(1);
          end else begin
            b_n = b - W'(1);
          end
          state_n = EVAL;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Decoded straight from the state register so an async reset drops
  // chk_valid immediately.
  assign chk.chk_valid = (state == ISSUE);
  assign chk.chk_value = val_r;

  assign busy     = (state == EVAL) || (state == ISSUE) || (state == WAIT);
  assign done     = (state == DONE);
  assign result   = best;
  assign factor_a = fa;
  assign factor_b = fb;
  assign checks   = checks_r;

endmodule

// File: tb/tb_palindrome_search_ctrl.sv
module tb_palindrome_search_ctrl;

  localparam int W  = 10;
  localparam int PW = 2 * W;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  lo, hi;
  logic          busy, done;
  logic [PW-1:0] result;
  logic [W-1:0]  factor_a, factor_b;
  logic [CW-1:0] checks;

  palindrome_search_ctrl_if #(.PW(PW)) ifc ();

  palindrome_search_ctrl #(.W(W), .PW(PW), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .lo       (lo),
    .hi       (hi),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .factor_a (factor_a),
    .factor_b (factor_b),
    .checks   (checks),
    .chk      (ifc.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [PW-1:0] result;
    logic [W-1:0]  fa;
    logic [W-1:0]  fb;
    logic [CW-1:0] checks;
    bit            use_checks;
  } exp_t;

  exp_t exp_q[$];
  bit   armed   = 0;
  bit   stall   = 0;
  bit   stray_req = 0;
  int   cv_rises = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_pal(input logic [PW-1:0] v);
    int t, r;
    t = int'(v);
    r = 0;
    while (t > 0) begin
      r = r * 10 + t % 10;
      t = t / 10;
    end
    return r == int'(v);
  endfunction

  // Behavioural checker: accepts when not stalled, answers 3 cycles later.
  initial begin : checker_model
    bit            pend = 0;
    int            cnt = 0;
    logic [PW-1:0] pval = '0;
    ifc.chk_ready = 1'b1;
    ifc.rsp_valid = 1'b0;
    ifc.rsp_pal   = 1'b0;
    forever begin
      @(negedge clk);
      ifc.rsp_valid = 1'b0;
      ifc.rsp_pal   = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          ifc.rsp_valid = 1'b1;
          ifc.rsp_pal   = is_pal(pval);
          pend = 0;
        end
      end else if (stray_req) begin
        ifc.rsp_valid = 1'b1;
        ifc.rsp_pal   = 1'b1;
        stray_req = 0;
      end
      ifc.chk_ready = !stall;
      if (rst_n && ifc.chk_valid && ifc.chk_ready && !pend) begin
        pend = 1;
        cnt  = 3;
        pval = ifc.chk_value;
      end
    end
  end

  // Monitor: compares each completed search against the scoreboard.
  initial begin : monitor
    logic cv_q = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifc.chk_valid && !cv_q) cv_rises++;
      cv_q = ifc.chk_valid;
      if (armed && done && rst_n) begin
        armed = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result",   64'(result),   64'(e.result));
          check("factor_a", 64'(factor_a), 64'(e.fa));
          check("factor_b", 64'(factor_b), 64'(e.fb));
          check("busy_at_done", 64'(busy), 0);
          if (e.use_checks) check("checks", 64'(checks), 64'(e.checks));
        end
      end
    end
  end

  task automatic push_exp(input int r, input int a, input int b, input int c, input bit uc);
    exp_t e;
    e.result = PW'(r);
    e.fa = W'(a);
    e.fb = W'(b);
    e.checks = CW'(c);
    e.use_checks = uc;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input int l, input int h, input bit arm);
    @(negedge clk);
    lo = W'(l);
    hi = W'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (arm) armed = 1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (armed && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (armed) begin
      check({name, "_timeout"}, 1, 0);
      armed = 0;
    end
  endtask

  task automatic wait_cv(input string name, input int budget);
    int n = 0;
    while (!ifc.chk_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.chk_valid) check({name, "_chk_valid_timeout"}, 1, 0);
  endtask

  initial begin : main
    int bad;
    int rises0;
    rst_n = 1'b0;
    start = 1'b0;
    lo = '0;
    hi = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      64'(busy), 0);
    check("rst_done",      64'(done), 0);
    check("rst_chk_valid", 64'(ifc.chk_valid), 0);
    check("rst_result",    64'(result), 0);
    check("rst_factor_a",  64'(factor_a), 0);
    check("rst_factor_b",  64'(factor_b), 0);
    check("rst_checks",    64'(checks), 0);
    check("rst_chk_value", 64'(ifc.chk_value), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // stray response while idle
    stray_req = 1;
    repeat (3) @(negedge clk);
    check("idle_stray_busy",   64'(busy), 0);
    check("idle_stray_done",   64'(done), 0);
    check("idle_stray_result", 64'(result), 0);

    // single pair 11*11, also start->chk_valid latency of 2 cycles
    push_exp(121, 11, 11, 1, 1);
    do_start(11, 11, 1);
    check("lat_cycle1_chk_valid", 64'(ifc.chk_valid), 0);
    check("lat_cycle1_busy", 64'(busy), 1);
    @(negedge clk);
    check("lat_cycle2_chk_valid", 64'(ifc.chk_valid), 1);
    check("lat_cycle2_chk_value", 64'(ifc.chk_value), 121);
    wait_done("s11", 100);

    push_exp(9009, 99, 91, 0, 0);
    do_start(10, 99, 1);
    wait_done("s2digit", 20000);

    // empty ranges: done immediately, no request
    rises0 = cv_rises;
    push_exp(0, 0, 0, 0, 1);
    do_start(20, 10, 1);
    check("empty1_done_fast", 64'(done), 1);
    wait_done("empty1", 5);
    push_exp(0, 0, 0, 0, 1);
    do_start(0, 0, 1);
    check("empty2_done_fast", 64'(done), 1);
    wait_done("empty2", 5);
    check("empty_no_chk_valid", 64'(cv_rises - rises0), 0);

    // stalled checker, stray response in ISSUE, start while busy
    stall = 1;
    repeat (2) @(negedge clk);
    push_exp(9009, 99, 91, 0, 0);
    do_start(10, 99, 1);
    wait_cv("stall", 10);
    check("stall_first_value", 64'(ifc.chk_value), 9801);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 10) stray_req = 1;
      if (i == 20) begin lo = W'(11); hi = W'(11); start = 1'b1; end
      if (i == 21) start = 1'b0;
      if (ifc.chk_valid !== 1'b1 || ifc.chk_value !== PW'(9801) ||
          checks !== '0 || busy !== 1'b1) bad++;
    end
    check("stall_stable_cycles_bad", 64'(bad), 0);
    stall = 0;
    wait_done("stall", 20000);

    // async reset while request pending in ISSUE
    stall = 1;
    repeat (2) @(negedge clk);
    do_start(10, 99, 0);
    wait_cv("rst_issue", 10);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_chk_valid", 64'(ifc.chk_valid), 0);
    check("async_rst_busy", 64'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 0;

    // async reset mid-WAIT with a late response still due
    do_start(10, 99, 0);
    wait_cv("rst_wait", 10);
    @(posedge clk);
    #2;
    check("pre_rst_checks", 64'(checks), 1);
    rst_n = 1'b0;
    #1;
    check("wait_rst_busy",      64'(busy), 0);
    check("wait_rst_done",      64'(done), 0);
    check("wait_rst_chk_valid", 64'(ifc.chk_valid), 0);
    check("wait_rst_result",    64'(result), 0);
    check("wait_rst_checks",    64'(checks), 0);
    check("wait_rst_chk_value", 64'(ifc.chk_value), 0);
    check("wait_rst_factor_a",  64'(factor_a), 0);
    check("wait_rst_factor_b",  64'(factor_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("late_rsp_busy",   64'(busy), 0);
    check("late_rsp_done",   64'(done), 0);
    check("late_rsp_checks", 64'(checks), 0);
    push_exp(9009, 99, 91, 0, 0);
    do_start(10, 99, 1);
    wait_done("after_rst", 20000);

    // full 3-digit search
    push_exp(906609, 993, 913, 0, 0);
    do_start(100, 999, 1);
    wait_done("s3digit", 60000);
    check("final_done", 64'(done), 1);

    check("scoreboard_left", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
